imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe_pkg.sv | 20 ++
 rtl/imm_gen_pipe_fmt_decode.sv | 38 +++
 rtl/imm_gen_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared immediate-format encodings and small helpers used by the decoder
// and by the pipelined immediate generator.
package imm_gen_pipe_pkg;

    localparam logic [2:0] IMM_FMT_I     = 3'b000;
    localparam logic [2:0] IMM_FMT_S     = 3'b001;
    localparam logic [2:0] IMM_FMT_B     = 3'b010;
    localparam logic [2:0] IMM_FMT_J     = 3'b011;
    localparam logic [2:0] IMM_FMT_U     = 3'b100;
    localparam logic [2:0] IMM_FMT_SHAMT = 3'b101;
    localparam logic [2:0] IMM_FMT_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_FMT_RSV   = 3'b111;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    function automatic logic fmt_is_reserved(input logic [2:0] fmt);
        return fmt == IMM_FMT_RSV;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_fmt_decode.sv
// Purely combinational immediate extraction for all RISC-V immediate
// formats, sign/zero-extended to XLEN.
module imm_fmt_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic signed [31:0] u_word;
    logic [5:0]         shamt;

    assign u_word = {instr[31:12], 12'b0};
    // RV64 shift amounts carry one extra bit.
    assign shamt  = {(XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};

    always_comb begin
        imm = '0;
        err = fmt_is_reserved(imm_src);
        case (imm_src)
            IMM_FMT_I:     imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_FMT_S:     imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_FMT_B:     imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            IMM_FMT_J:     imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            IMM_FMT_U:     imm = XLEN'(u_word);
            IMM_FMT_SHAMT: imm = XLEN'(shamt);
            IMM_FMT_ZIMM:  imm = XLEN'(instr[19:15]);
            default:       imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a valid/ready handshake with a 2-entry skid
// buffer (output register + skid register) and a saturating error counter.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_immSrc,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [TAGW-1:0] out_tag,
    output logic            out_err,
    output logic [7:0]      err_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    imm_fmt_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm_src (in_immSrc),
        .imm     (dec_imm),
        .err     (dec_err)
    );

    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic [TAGW-1:0] out_tag_q,   out_tag_d;
    logic            out_err_q,   out_err_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
    logic [TAGW-1:0] skid_tag_q,  skid_tag_d;
    logic            skid_err_q,  skid_err_d;
    logic [7:0]      err_cnt_q,   err_cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        err_cnt_d    = err_cnt_q;

        if (out_fire) begin
            // in_ready is low whenever the skid is full, so a skid refill
            // never coincides with a new acceptance.
            if (skid_valid_q) begin
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_imm_d = dec_imm;
                out_tag_d = in_tag;
                out_err_d = dec_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (in_fire) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_tag_d   = in_tag;
                out_err_d   = dec_err;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_tag_d   = in_tag;
            skid_err_d   = dec_err;
        end

        in_ready_d = !skid_valid_d;

        if (out_fire && out_err_q && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
